// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Holds opcode encodings, register address type, FSM state enum and widths.
package pipeline_ctrl_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned PERF_W = 16;

  typedef logic [OP_W-1:0]  opcode_t;
  typedef logic [REG_W-1:0] reg_addr_t;

  // Opcode map (inst[15:12])
  localparam opcode_t OP_NOP  = 4'b0000;
  localparam opcode_t OP_ADD  = 4'b0001;
  localparam opcode_t OP_SUB  = 4'b0010;
  localparam opcode_t OP_AND  = 4'b0011;
  localparam opcode_t OP_OR   = 4'b0100;
  localparam opcode_t OP_ADDI = 4'b0101;
  localparam opcode_t OP_SHL  = 4'b0110;
  localparam opcode_t OP_SHR  = 4'b0111;
  localparam opcode_t OP_LDI  = 4'b1000;
  localparam opcode_t OP_OUT  = 4'b1001;
  localparam opcode_t OP_LD   = 4'b1010;
  localparam opcode_t OP_BR   = 4'b1011;
  localparam opcode_t OP_ST   = 4'b1100;
  localparam opcode_t OP_BEQ  = 4'b1101;
  localparam opcode_t OP_JMP  = 4'b1110;
  localparam opcode_t OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_DRAIN      = 2'd2,
    ST_HALTED     = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master: datapath side (drives decode/execute fields, receives controls).
// slave : controller side.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  opcode_t             dec_op;
  reg_addr_t           dec_rd;
  reg_addr_t           dec_rs;
  logic                exe_is_mem_read;
  reg_addr_t           exe_rd;
  logic                exe_branch_taken;
  logic                pc_stall;
  logic                fd_stall;
  logic                de_bubble;
  logic                fd_flush;
  logic                de_flush;
  logic                halted;
  logic [PERF_W-1:0]   stall_count;
  logic [PERF_W-1:0]   flush_count;

  modport master (
    output dec_op, dec_rd, dec_rs, exe_is_mem_read, exe_rd, exe_branch_taken,
    input  pc_stall, fd_stall, de_bubble, fd_flush, de_flush, halted,
    input  stall_count, flush_count
  );

  modport slave (
    input  dec_op, dec_rd, dec_rs, exe_is_mem_read, exe_rd, exe_branch_taken,
    output pc_stall, fd_stall, de_bubble, fd_flush, de_flush, halted,
    output stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl_operand_use.sv
// Opcode -> register-field usage decoder; shared with the decode stage.
// Ports: i_op (opcode), o_uses_rd, o_uses_rs.
module pipeline_ctrl_operand_use
  import pipeline_ctrl_pkg::*;
(
  input  opcode_t i_op,
  output logic    o_uses_rd,
  output logic    o_uses_rs
);

  always_comb begin
    o_uses_rd = 1'b0;
    o_uses_rs = 1'b0;
    case (i_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD, OP_ST, OP_BEQ: begin
        o_uses_rd = 1'b1;
        o_uses_rs = 1'b1;
      end
      OP_ADDI, OP_SHL, OP_SHR: o_uses_rd = 1'b1;
      OP_OUT:                  o_uses_rs = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 4-stage in-order pipeline.
// Ports: clk, rst (async, active-low), bus (pipeline_ctrl_if.slave):
//   in : dec_op/dec_rd/dec_rs, exe_is_mem_read, exe_rd, exe_branch_taken
//   out: pc_stall, fd_stall, de_bubble, fd_flush, de_flush, halted (Mealy),
//        stall_count, flush_count (perf counters)
// Build option: PIPELINE_PERF_CNT_EN enables the saturating perf counters;
// otherwise both counter outputs are tied to 0.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES      = 3
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  localparam logic [1:0] S_RUN        = ST_RUN;
  localparam logic [1:0] S_LOAD_STALL = ST_LOAD_STALL;
  localparam logic [1:0] S_DRAIN      = ST_DRAIN;
  localparam logic [1:0] S_HALTED     = ST_HALTED;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_uses_rd;
  logic w_uses_rs;
  logic w_load_use;

  logic w_pc_stall;
  logic w_fd_stall;
  logic w_de_bubble;
  logic w_fd_flush;
  logic w_de_flush;
  logic w_halted;

  pipeline_ctrl_operand_use u_operand_use (
    .i_op      (bus.dec_op),
    .o_uses_rd (w_uses_rd),
    .o_uses_rs (w_uses_rs)
  );

  // Load in execute feeding a field the decode instruction actually reads
  assign w_load_use = bus.exe_is_mem_read &&
                      ((w_uses_rd && (bus.dec_rd == bus.exe_rd)) ||
                       (w_uses_rs && (bus.dec_rs == bus.exe_rd)));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and Mealy outputs; taken branch outranks everything but HALTED
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_stall  = 1'b0;
    w_fd_stall  = 1'b0;
    w_de_bubble = 1'b0;
    w_fd_flush  = 1'b0;
    w_de_flush  = 1'b0;
    w_halted    = 1'b0;

    case (r_state)
      S_RUN: begin
        if (bus.exe_branch_taken) begin
          w_fd_flush  = 1'b1;
          w_de_flush  = 1'b1;
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else if (bus.dec_op == OP_HALT) begin
          // Halt itself travels on as a NOP, so no bubble this cycle
          w_pc_stall  = 1'b1;
          w_fd_stall  = 1'b1;
          w_cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
          w_state_nxt = S_DRAIN;
        end else if (bus.dec_op == OP_JMP) begin
          w_fd_flush  = 1'b1;
        end else if (w_load_use) begin
          w_pc_stall  = 1'b1;
          w_fd_stall  = 1'b1;
          w_de_bubble = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            w_cnt_nxt   = CNT_W'(LOAD_STALL_CYCLES - 2);
            w_state_nxt = S_LOAD_STALL;
          end
        end
      end

      S_LOAD_STALL: begin
        if (bus.exe_branch_taken) begin
          w_fd_flush  = 1'b1;
          w_de_flush  = 1'b1;
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          // Execute already holds a bubble, so hazard is not re-checked
          w_pc_stall  = 1'b1;
          w_fd_stall  = 1'b1;
          w_de_bubble = 1'b1;
          if (r_cnt == '0) w_state_nxt = S_RUN;
          else             w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end

      S_DRAIN: begin
        if (bus.exe_branch_taken) begin
          w_fd_flush  = 1'b1;
          w_de_flush  = 1'b1;
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_pc_stall  = 1'b1;
          w_fd_stall  = 1'b1;
          w_de_bubble = 1'b1;
          if (r_cnt == '0) w_state_nxt = S_HALTED;
          else             w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end

      S_HALTED: begin
        w_pc_stall  = 1'b1;
        w_fd_stall  = 1'b1;
        w_de_bubble = 1'b1;
        w_halted    = 1'b1;
      end

      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end
    endcase

    // Outputs must be quiet while reset is held, whatever the inputs show
    if (!rst) begin
      w_pc_stall  = 1'b0;
      w_fd_stall  = 1'b0;
      w_de_bubble = 1'b0;
      w_fd_flush  = 1'b0;
      w_de_flush  = 1'b0;
      w_halted    = 1'b0;
    end
  end

  assign bus.pc_stall  = w_pc_stall;
  assign bus.fd_stall  = w_fd_stall;
  assign bus.de_bubble = w_de_bubble;
  assign bus.fd_flush  = w_fd_flush;
  assign bus.de_flush  = w_de_flush;
  assign bus.halted    = w_halted;

`ifdef PIPELINE_PERF_CNT_EN
  logic [PERF_W-1:0] r_stall_count;
  logic [PERF_W-1:0] r_flush_count;

  // Saturating perf counters; halted cycles are not counted as stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_pc_stall && !w_halted && (r_stall_count != '1))
        r_stall_count <= r_stall_count + PERF_W'(1);
      if ((w_fd_flush || w_de_flush) && (r_flush_count != '1))
        r_flush_count <= r_flush_count + PERF_W'(1);
    end
  end

  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;
`else
  assign bus.stall_count = '0;
  assign bus.flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table for single-cycle decisions,
// hand sequences for load stall, halt drain, halt cancel and async reset.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

`ifdef PIPELINE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;

  pipeline_ctrl_if if_a ();
  pipeline_ctrl_if if_b ();

  pipeline_ctrl #(.LOAD_STALL_CYCLES(1), .DRAIN_CYCLES(3)) dut_a (
    .clk (clk), .rst (rst), .bus (if_a.slave)
  );
  pipeline_ctrl #(.LOAD_STALL_CYCLES(3), .DRAIN_CYCLES(3)) dut_b (
    .clk (clk), .rst (rst), .bus (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs;
    logic       mr;
    logic [3:0] erd;
    logic       br;
    logic [5:0] exp;   // {pc_stall, fd_stall, de_bubble, fd_flush, de_flush, halted}
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_STALL = 6'b111000;
  localparam logic [5:0] O_HLTD  = 6'b110000;
  localparam logic [5:0] O_BRF   = 6'b000110;
  localparam logic [5:0] O_JMP   = 6'b000100;
  localparam logic [5:0] O_HALT  = 6'b111001;

  function automatic logic [5:0] outs_a();
    return {if_a.pc_stall, if_a.fd_stall, if_a.de_bubble,
            if_a.fd_flush, if_a.de_flush, if_a.halted};
  endfunction

  function automatic logic [5:0] outs_b();
    return {if_b.pc_stall, if_b.fd_stall, if_b.de_bubble,
            if_b.fd_flush, if_b.de_flush, if_b.halted};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic mr, input logic [3:0] erd, input logic br);
    if_a.dec_op = op;  if_a.dec_rd = rd;  if_a.dec_rs = rs;
    if_a.exe_is_mem_read = mr;  if_a.exe_rd = erd;  if_a.exe_branch_taken = br;
    if_b.dec_op = op;  if_b.dec_rd = rd;  if_b.dec_rs = rs;
    if_b.exe_is_mem_read = mr;  if_b.exe_rd = erd;  if_b.exe_branch_taken = br;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, O_IDLE};
    vecs[1]  = '{4'h1, 4'h3, 4'h0, 1'b1, 4'h3, 1'b0, O_STALL};
    vecs[2]  = '{4'h1, 4'h0, 4'h3, 1'b1, 4'h3, 1'b0, O_STALL};
    vecs[3]  = '{4'h8, 4'h3, 4'h0, 1'b1, 4'h3, 1'b0, O_IDLE};
    vecs[4]  = '{4'h5, 4'h0, 4'h3, 1'b1, 4'h3, 1'b0, O_IDLE};
    vecs[5]  = '{4'h5, 4'h3, 4'h0, 1'b1, 4'h3, 1'b0, O_STALL};
    vecs[6]  = '{4'h9, 4'h0, 4'h3, 1'b1, 4'h3, 1'b0, O_STALL};
    vecs[7]  = '{4'h9, 4'h3, 4'h0, 1'b1, 4'h3, 1'b0, O_IDLE};
    vecs[8]  = '{4'h1, 4'h3, 4'h0, 1'b1, 4'h3, 1'b1, O_BRF};
    vecs[9]  = '{4'hE, 4'h3, 4'h3, 1'b1, 4'h3, 1'b0, O_JMP};
    vecs[10] = '{4'hF, 4'h3, 4'h3, 1'b1, 4'h3, 1'b0, O_HLTD};
    vecs[11] = '{4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, O_BRF};
    vecs[12] = '{4'h1, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, O_STALL};
    vecs[13] = '{4'h1, 4'h3, 4'h3, 1'b0, 4'h3, 1'b0, O_IDLE};
    vecs[14] = '{4'hA, 4'h0, 4'h3, 1'b1, 4'h3, 1'b0, O_STALL};
    vecs[15] = '{4'hC, 4'h3, 4'h0, 1'b1, 4'h3, 1'b0, O_STALL};
    vecs[16] = '{4'hD, 4'h0, 4'h3, 1'b1, 4'h3, 1'b0, O_STALL};
    vecs[17] = '{4'h4, 4'h3, 4'h0, 1'b1, 4'h3, 1'b0, O_STALL};
    vecs[18] = '{4'hB, 4'h3, 4'h3, 1'b1, 4'h3, 1'b0, O_IDLE};
    vecs[19] = '{4'h0, 4'h3, 4'h3, 1'b1, 4'h3, 1'b0, O_IDLE};
    vecs[20] = '{4'h7, 4'h3, 4'h0, 1'b1, 4'h3, 1'b0, O_STALL};
    vecs[21] = '{4'h6, 4'h0, 4'h3, 1'b1, 4'h3, 1'b0, O_IDLE};
    vecs[22] = '{4'h2, 4'h5, 4'h7, 1'b1, 4'h7, 1'b0, O_STALL};
    vecs[23] = '{4'h3, 4'h5, 4'h7, 1'b1, 4'h6, 1'b0, O_IDLE};
    vecs[24] = '{4'hE, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, O_BRF};

    rst = 1'b1;
    drive(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);

    // Reset state with idle inputs
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_outs", 16'(outs_a()), 16'(O_IDLE));
    check("reset_stall_cnt", if_a.stall_count, 16'h0);
    check("reset_flush_cnt", if_a.flush_count, 16'h0);
    @(negedge clk);
    rst = 1'b1;

    // Single-cycle decisions from RUN
    for (int i = 0; i < NV; i++) begin
      do_reset();
      drive(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].mr, vecs[i].erd, vecs[i].br);
      #1;
      check($sformatf("vec%0d", i), 16'(outs_a()), 16'(vecs[i].exp));
    end

    // Load-use with one bubble: stall exactly one cycle
    do_reset();
    drive(4'h1, 4'h3, 4'h0, 1'b1, 4'h3, 1'b0);
    #1 check("lu1_c0", 16'(outs_a()), 16'(O_STALL));
    @(negedge clk);
    drive(4'h1, 4'h3, 4'h0, 1'b0, 4'h0, 1'b0);
    #1 check("lu1_c1", 16'(outs_a()), 16'(O_IDLE));
    check("lu1_stall_cnt", if_a.stall_count, PERF ? 16'd1 : 16'd0);

    // Load-use with three bubbles on dut_b
    do_reset();
    drive(4'h1, 4'h3, 4'h0, 1'b1, 4'h3, 1'b0);
    #1 check("lu3_c0", 16'(outs_b()), 16'(O_STALL));
    @(negedge clk);
    drive(4'h1, 4'h3, 4'h0, 1'b0, 4'h0, 1'b0);
    #1 check("lu3_c1", 16'(outs_b()), 16'(O_STALL));
    @(negedge clk);
    #1 check("lu3_c2", 16'(outs_b()), 16'(O_STALL));
    @(negedge clk);
    #1 check("lu3_c3", 16'(outs_b()), 16'(O_IDLE));
    check("lu3_stall_cnt", if_b.stall_count, PERF ? 16'd3 : 16'd0);

    // Branch beats load-use; counted as one flush event
    do_reset();
    drive(4'h1, 4'h3, 4'h0, 1'b1, 4'h3, 1'b1);
    #1 check("brlu_c0", 16'(outs_a()), 16'(O_BRF));
    @(negedge clk);
    drive(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    #1 check("brlu_c1", 16'(outs_a()), 16'(O_IDLE));
    check("brlu_flush_cnt", if_a.flush_count, PERF ? 16'd1 : 16'd0);
    check("brlu_stall_cnt", if_a.stall_count, 16'd0);

    // Halt drain: decode cycle, three drain cycles, then halted forever
    do_reset();
    drive(4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    #1 check("halt_c0", 16'(outs_a()), 16'(O_HLTD));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      #1 check($sformatf("drain_c%0d", c), 16'(outs_a()), 16'(O_STALL));
    end
    @(negedge clk);
    #1 check("halted_c4", 16'(outs_a()), 16'(O_HALT));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(4'(c * 5 + 1), 4'h3, 4'h3, c[0], 4'h3, ~c[0]);
      #1 check($sformatf("halted_hold%0d", c), 16'(outs_a()), 16'(O_HALT));
    end
    check("halt_stall_cnt", if_a.stall_count, PERF ? 16'd4 : 16'd0);

    // Asynchronous reset in the middle of a drain
    do_reset();
    drive(4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    #1 check("rstd_drain", 16'(outs_a()), 16'(O_STALL));
    #2 rst = 1'b0;
    #1 check("rstd_outs", 16'(outs_a()), 16'(O_IDLE));
    check("rstd_stall_cnt", if_a.stall_count, 16'd0);
    @(negedge clk);
    drive(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #1 check("rstd_after", 16'(outs_a()), 16'(O_IDLE));

    // Halt cancelled by a taken branch during drain
    do_reset();
    drive(4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    #1 check("hc_c0", 16'(outs_a()), 16'(O_HLTD));
    @(negedge clk);
    drive(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1);
    #1 check("hc_flush", 16'(outs_a()), 16'(O_BRF));
    @(negedge clk);
    drive(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1 check($sformatf("hc_run%0d", c), 16'(outs_a()), 16'(O_IDLE));
      @(negedge clk);
    end
    check("hc_flush_cnt", if_a.flush_count, PERF ? 16'd1 : 16'd0);
    check("hc_stall_cnt", if_a.stall_count, PERF ? 16'd1 : 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
